match_turn_ctrl: RTL and testbench

Turn sequencer for the 6x6 memory-match game. Accepts cursor selections from the key/button front end and reads card symbols from the card memory. Compares each pair, holds mismatched pairs visible for a fixed time, then hides them, and maintains the found-card map, the attempt counter and game-over. Sits between the input decoder and the LED driver, and is the only master of the card-memory read port.

---
 rtl/game_pkg.sv | 33 +++
 rtl/show_timer.sv | 35 +++
 rtl/match_turn_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_match_turn_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared board constants, types and helpers for the memory-match game.
package game_pkg;

   localparam int GRID_CELLS = 36;
   localparam int LOC_W      = 6;
   localparam int SYM_W      = 5;
   localparam int LOC_SPAN   = 2 ** LOC_W;

   typedef logic [LOC_W-1:0] loc_t;
   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PICK1 = 3'd1,
      READ1 = 3'd2,
      PICK2 = 3'd3,
      READ2 = 3'd4,
      CMP   = 3'd5,
      SHOW  = 3'd6,
      DONE  = 3'd7
   } turn_state_t;

   localparam logic [GRID_CELLS-1:0] ALL_FOUND = {GRID_CELLS{1'b1}};

   // One-hot mask over the full location space for a single location.
   function automatic logic [LOC_SPAN-1:0] loc_mask(input loc_t loc);
      logic [LOC_SPAN-1:0] m;
      m      = {LOC_SPAN{1'b0}};
      m[loc] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/show_timer.sv
// show_timer: loadable down-counter that times how long a mismatched pair stays visible.
module show_timer #(
   parameter int SHOW_CYCLES = 25_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(SHOW_CYCLES - 1);

   logic [TW-1:0] count_r;

   // Counter: clear beats load, load beats count-down; stops at zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {TW{1'b0}};
      end else if (clr) begin
         count_r <= {TW{1'b0}};
      end else if (load) begin
         count_r <= LOAD_VAL;
      end else if (en && (count_r != {TW{1'b0}})) begin
         count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == {TW{1'b0}});

endmodule

// File: rtl/match_turn_ctrl.sv
// match_turn_ctrl: turn sequencer for the 6x6 memory-match game. Takes cursor
// selections, reads both card symbols, compares them, times the mismatch
// display and keeps the found map, attempt count and game-over flag.
module match_turn_ctrl
   import game_pkg::*;
#(
   parameter int SHOW_CYCLES = 25_000_000,
   parameter int ATT_W       = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  new_game,
   input  logic                  sel_valid,
   input  logic [LOC_W-1:0]      sel_loc,
   output logic                  mem_rd,
   output logic [LOC_W-1:0]      mem_addr,
   input  logic [SYM_W-1:0]      mem_data,
   output logic [LOC_W-1:0]      card1_loc,
   output logic [LOC_W-1:0]      card2_loc,
   output logic                  card1_vis,
   output logic                  card2_vis,
   output logic [GRID_CELLS-1:0] found,
   output logic [ATT_W-1:0]      attempts,
   output logic                  match_p,
   output logic                  mismatch_p,
   output logic                  busy,
   output logic                  game_over
);

   localparam logic [ATT_W-1:0] ATT_MAX = {ATT_W{1'b1}};
   localparam logic [ATT_W-1:0] ATT_ONE = {{(ATT_W-1){1'b0}}, 1'b1};

   turn_state_t           state_r;
   logic                  mem_rd_r;
   loc_t                  mem_addr_r;
   loc_t                  card1_loc_r;
   loc_t                  card2_loc_r;
   logic                  card1_vis_r;
   logic                  card2_vis_r;
   logic [GRID_CELLS-1:0] found_r;
   logic [ATT_W-1:0]      attempts_r;
   logic                  match_p_r;
   logic                  mismatch_p_r;
   logic                  busy_r;
   logic                  game_over_r;
   // High in the cycle where the card memory presents the data of the last read.
   logic                  rd_d_r;
   sym_t                  sym1_r;

   logic [LOC_SPAN-1:0]   found_ext_s;
   logic                  sel_free_s;
   logic                  pick1_ok_s;
   logic                  pick2_ok_s;
   logic                  sym_eq_s;
   logic [GRID_CELLS-1:0] found_upd_s;
   logic                  timer_load_s;
   logic                  timer_en_s;
   logic                  timer_done_s;

   // Selection qualification: location on the board and not already matched.
   always_comb begin
      found_ext_s = LOC_SPAN'(found_r);
      sel_free_s  = 1'b0;
      if (sel_loc < loc_t'(GRID_CELLS)) begin
         sel_free_s = ~found_ext_s[sel_loc];
      end else begin
         sel_free_s = 1'b0;
      end
      pick1_ok_s = sel_valid & sel_free_s;
      pick2_ok_s = pick1_ok_s & (sel_loc != card1_loc_r);
   end

   // Compare second symbol straight off the memory bus against the stored first one.
   always_comb begin
      sym_eq_s    = (sym1_r == mem_data);
      found_upd_s = found_r
                  | GRID_CELLS'(loc_mask(card1_loc_r))
                  | GRID_CELLS'(loc_mask(card2_loc_r));
   end

   // Show-timer control: load on a mismatch result, count only while showing.
   always_comb begin
      timer_load_s = 1'b0;
      timer_en_s   = 1'b0;
      if (state_r == CMP) begin
         timer_load_s = ~sym_eq_s;
      end else if (state_r == SHOW) begin
         timer_en_s = 1'b1;
      end else begin
         timer_load_s = 1'b0;
         timer_en_s   = 1'b0;
      end
   end

   show_timer #(
      .SHOW_CYCLES (SHOW_CYCLES)
   ) u_show_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (new_game),
      .load    (timer_load_s),
      .en      (timer_en_s),
      .done    (timer_done_s)
   );

   // Turn FSM with all outputs registered; new_game overrides every state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         mem_rd_r     <= 1'b0;
         mem_addr_r   <= {LOC_W{1'b0}};
         card1_loc_r  <= {LOC_W{1'b0}};
         card2_loc_r  <= {LOC_W{1'b0}};
         card1_vis_r  <= 1'b0;
         card2_vis_r  <= 1'b0;
         found_r      <= {GRID_CELLS{1'b0}};
         attempts_r   <= {ATT_W{1'b0}};
         match_p_r    <= 1'b0;
         mismatch_p_r <= 1'b0;
         busy_r       <= 1'b1;
         game_over_r  <= 1'b0;
         rd_d_r       <= 1'b0;
         sym1_r       <= {SYM_W{1'b0}};
      end else if (new_game) begin
         state_r      <= PICK1;
         mem_rd_r     <= 1'b0;
         card1_vis_r  <= 1'b0;
         card2_vis_r  <= 1'b0;
         found_r      <= {GRID_CELLS{1'b0}};
         attempts_r   <= {ATT_W{1'b0}};
         match_p_r    <= 1'b0;
         mismatch_p_r <= 1'b0;
         busy_r       <= 1'b0;
         game_over_r  <= 1'b0;
         rd_d_r       <= 1'b0;
      end else begin
         mem_rd_r     <= 1'b0;
         match_p_r    <= 1'b0;
         mismatch_p_r <= 1'b0;
         rd_d_r       <= mem_rd_r;
         case (state_r)
            IDLE: begin
               busy_r <= 1'b1;
            end
            PICK1: begin
               if (pick1_ok_s) begin
                  card1_loc_r <= sel_loc;
                  card1_vis_r <= 1'b1;
                  mem_rd_r    <= 1'b1;
                  mem_addr_r  <= sel_loc;
                  busy_r      <= 1'b1;
                  state_r     <= READ1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            READ1: begin
               busy_r  <= 1'b0;
               state_r <= PICK2;
            end
            PICK2: begin
               // First symbol arrives in the first PICK2 cycle.
               if (rd_d_r) begin
                  sym1_r <= mem_data;
               end else begin
                  sym1_r <= sym1_r;
               end
               if (pick2_ok_s) begin
                  card2_loc_r <= sel_loc;
                  card2_vis_r <= 1'b1;
                  mem_rd_r    <= 1'b1;
                  mem_addr_r  <= sel_loc;
                  busy_r      <= 1'b1;
                  state_r     <= READ2;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            READ2: begin
               busy_r  <= 1'b1;
               state_r <= CMP;
            end
            CMP: begin
               if (attempts_r != ATT_MAX) begin
                  attempts_r <= attempts_r + ATT_ONE;
               end else begin
                  attempts_r <= attempts_r;
               end
               if (sym_eq_s) begin
                  found_r     <= found_upd_s;
                  match_p_r   <= 1'b1;
                  card1_vis_r <= 1'b0;
                  card2_vis_r <= 1'b0;
                  if (found_upd_s == ALL_FOUND) begin
                     game_over_r <= 1'b1;
                     busy_r      <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= PICK1;
                  end
               end else begin
                  mismatch_p_r <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= SHOW;
               end
            end
            SHOW: begin
               if (timer_done_s) begin
                  card1_vis_r <= 1'b0;
                  card2_vis_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= PICK1;
               end else begin
                  busy_r <= 1'b1;
               end
            end
            DONE: begin
               busy_r      <= 1'b1;
               game_over_r <= 1'b1;
            end
            default: begin
               busy_r  <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mem_rd     = mem_rd_r;
   assign mem_addr   = mem_addr_r;
   assign card1_loc  = card1_loc_r;
   assign card2_loc  = card2_loc_r;
   assign card1_vis  = card1_vis_r;
   assign card2_vis  = card2_vis_r;
   assign found      = found_r;
   assign attempts   = attempts_r;
   assign match_p    = match_p_r;
   assign mismatch_p = mismatch_p_r;
   assign busy       = busy_r;
   assign game_over  = game_over_r;

endmodule

// File: tb/tb_match_turn_ctrl.sv
// tb_match_turn_ctrl: self-checking bench for the match-game turn sequencer.
module tb_match_turn_ctrl;

   localparam int SC = 4;
   localparam logic [35:0] ALL = {36{1'b1}};

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        new_game = 1'b0;
   logic        sel_valid = 1'b0;
   logic [5:0]  sel_loc = 6'd0;
   logic        mem_rd;
   logic [5:0]  mem_addr;
   logic [4:0]  mem_data = 5'd0;
   logic [5:0]  card1_loc, card2_loc;
   logic        card1_vis, card2_vis;
   logic [35:0] found;
   logic [7:0]  attempts;
   logic        match_p, mismatch_p, busy, game_over;

   int tests = 0;
   int fails = 0;

   // Reference game state
   logic [35:0] m_found = 36'd0;
   logic [7:0]  m_att = 8'd0;

   logic [4:0] rom [0:63];

   match_turn_ctrl #(.SHOW_CYCLES(SC), .ATT_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .new_game(new_game),
      .sel_valid(sel_valid), .sel_loc(sel_loc),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .card1_loc(card1_loc), .card2_loc(card2_loc),
      .card1_vis(card1_vis), .card2_vis(card2_vis),
      .found(found), .attempts(attempts),
      .match_p(match_p), .mismatch_p(mismatch_p),
      .busy(busy), .game_over(game_over)
   );

   // Clock generator
   always #5 clock = ~clock;

   // Card ROM with one cycle of read latency
   always @(posedge clock) begin
      if (mem_rd) mem_data <= rom[mem_addr];
   end

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      m_found = 36'd0;
      m_att = 8'd0;
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Stimulus only: plays a full pair selection and reports what was seen.
   task automatic play_turn(input int a, input int b, output logic rd_a, output logic rd_b,
                            output logic pre, output logic mp, output logic mmp);
      sel_valid = 1'b1; sel_loc = a[5:0];
      step();
      sel_valid = 1'b0;
      rd_a = mem_rd && (mem_addr == a[5:0]);
      step();
      sel_valid = 1'b1; sel_loc = b[5:0];
      step();
      sel_valid = 1'b0;
      rd_b = mem_rd && (mem_addr == b[5:0]);
      step();
      pre = match_p | mismatch_p;
      step();
      mp = match_p;
      mmp = mismatch_p;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      if ({mem_rd, mem_addr, card1_loc, card2_loc, card1_vis, card2_vis, match_p, mismatch_p, game_over} !== 21'd0) begin
         $display("FAIL reset_outs: got %h expected 0", {mem_rd, mem_addr, card1_loc, card2_loc, card1_vis, card2_vis, match_p, mismatch_p, game_over}); fails++;
      end
      tests++;
      if (found !== 36'd0 || attempts !== 8'd0) begin
         $display("FAIL reset_found_att: got %h/%0d expected 0/0", found, attempts); fails++;
      end
      tests++;
      if (busy !== 1'b1) begin
         $display("FAIL reset_busy: got %b expected 1", busy); fails++;
      end
      tests++;
      reset_n = 1'b1;
      sel_valid = 1'b1; sel_loc = 6'd3;
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL idle_ignores_sel: got rd=%b busy=%b expected 0 1", mem_rd, busy); fails++;
      end
      tests++;
   endtask

   task automatic test_first_match();
      logic ra, rb, pre, mp, mmp;
      pulse_new_game();
      if (busy !== 1'b0 || found !== 36'd0) begin
         $display("FAIL newgame_pick1: got busy=%b found=%h expected 0 0", busy, found); fails++;
      end
      tests++;
      play_turn(0, 1, ra, rb, pre, mp, mmp);
      m_found[0] = 1'b1; m_found[1] = 1'b1; m_att = sat_inc(m_att);
      if ({ra, rb, pre, mp, mmp} !== 5'b11010) begin
         $display("FAIL match_timing: got %b expected 11010", {ra, rb, pre, mp, mmp}); fails++;
      end
      tests++;
      if (found !== m_found || attempts !== m_att || card1_vis !== 1'b0 || card2_vis !== 1'b0) begin
         $display("FAIL match_state: got found=%h att=%0d vis=%b%b expected %h %0d 00", found, attempts, card1_vis, card2_vis, m_found, m_att); fails++;
      end
      tests++;
      step();
      if (match_p !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL match_pulse_width: got match_p=%b busy=%b expected 0 0", match_p, busy); fails++;
      end
      tests++;
   endtask

   task automatic test_mismatch();
      logic ra, rb, pre, mp, mmp;
      play_turn(2, 5, ra, rb, pre, mp, mmp);
      m_att = sat_inc(m_att);
      if ({ra, rb, pre, mp, mmp} !== 5'b11001) begin
         $display("FAIL mismatch_timing: got %b expected 11001", {ra, rb, pre, mp, mmp}); fails++;
      end
      tests++;
      if (found !== m_found || attempts !== m_att || card1_vis !== 1'b1 || card2_vis !== 1'b1) begin
         $display("FAIL mismatch_state: got found=%h att=%0d vis=%b%b expected %h %0d 11", found, attempts, card1_vis, card2_vis, m_found, m_att); fails++;
      end
      tests++;
      for (int k = 1; k <= SC; k++) begin
         step();
         if (card1_vis !== (k < SC) || card2_vis !== (k < SC) || mismatch_p !== 1'b0) begin
            $display("FAIL show_window k=%0d: got vis=%b%b mis=%b expected %b%b 0", k, card1_vis, card2_vis, mismatch_p, k < SC, k < SC); fails++;
         end
         tests++;
      end
      if (busy !== 1'b0 || card1_loc !== 6'd2 || card2_loc !== 6'd5) begin
         $display("FAIL show_exit: got busy=%b locs=%0d,%0d expected 0 2,5", busy, card1_loc, card2_loc); fails++;
      end
      tests++;
   endtask

   task automatic test_rejections();
      logic ra, rb, pre, mp, mmp;
      int bad [3] = '{0, 40, 63};
      for (int i = 0; i < 3; i++) begin
         sel_valid = 1'b1; sel_loc = 6'(bad[i]);
         step();
         sel_valid = 1'b0;
         if (mem_rd !== 1'b0 || busy !== 1'b0 || card1_vis !== 1'b0) begin
            $display("FAIL reject_pick1 loc=%0d: got rd=%b busy=%b vis=%b expected 0 0 0", bad[i], mem_rd, busy, card1_vis); fails++;
         end
         tests++;
      end
      sel_valid = 1'b1; sel_loc = 6'd6;
      step();
      step();
      sel_loc = 6'd6;
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b0 || busy !== 1'b0 || card2_vis !== 1'b0) begin
         $display("FAIL reject_same_loc: got rd=%b busy=%b vis2=%b expected 0 0 0", mem_rd, busy, card2_vis); fails++;
      end
      tests++;
      sel_valid = 1'b1; sel_loc = 6'd7;
      step();
      sel_valid = 1'b0;
      step();
      step();
      m_found[6] = 1'b1; m_found[7] = 1'b1; m_att = sat_inc(m_att);
      if (match_p !== 1'b1 || attempts !== m_att || found !== m_found || card2_loc !== 6'd7) begin
         $display("FAIL after_reject_match: got mp=%b att=%0d found=%h loc2=%0d expected 1 %0d %h 7", match_p, attempts, found, card2_loc, m_att, m_found); fails++;
      end
      tests++;
      play_turn(8, 11, ra, rb, pre, mp, mmp);
      m_att = sat_inc(m_att);
      sel_valid = 1'b1; sel_loc = 6'd9;
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b0 || busy !== 1'b1 || card1_loc !== 6'd8 || card1_vis !== 1'b1) begin
         $display("FAIL reject_in_show: got rd=%b busy=%b loc1=%0d vis=%b expected 0 1 8 1", mem_rd, busy, card1_loc, card1_vis); fails++;
      end
      tests++;
      repeat (SC - 1) step();
      if (busy !== 1'b0 || card1_vis !== 1'b0 || card1_loc !== 6'd8 || attempts !== m_att || found !== m_found) begin
         $display("FAIL show_sel_lost: got busy=%b vis=%b loc1=%0d att=%0d found=%h expected 0 0 8 %0d %h", busy, card1_vis, card1_loc, attempts, found, m_att, m_found); fails++;
      end
      tests++;
   endtask

   task automatic test_random_play();
      logic ra, rb, pre, mp, mmp, exp_m;
      int a, b, c, turns;
      pulse_new_game();
      turns = 0;
      while (m_found != ALL && turns < 300) begin
         turns++;
         if ($urandom_range(0, 3) == 0) begin
            if (m_found != 36'd0 && $urandom_range(0, 1) == 1) begin
               do c = $urandom_range(0, 35); while (!m_found[c]);
            end else begin
               c = 36 + $urandom_range(0, 27);
            end
            sel_valid = 1'b1; sel_loc = c[5:0];
            step();
            sel_valid = 1'b0;
            if (mem_rd !== 1'b0 || busy !== 1'b0) begin
               $display("FAIL rand_reject loc=%0d: got rd=%b busy=%b expected 0 0", c, mem_rd, busy); fails++;
            end
            tests++;
         end
         do a = $urandom_range(0, 35); while (m_found[a]);
         if ($urandom_range(0, 1) == 1) b = a ^ 1;
         else begin
            do b = $urandom_range(0, 35); while (m_found[b] || b == a);
         end
         exp_m = ((a / 2) == (b / 2));
         play_turn(a, b, ra, rb, pre, mp, mmp);
         m_att = sat_inc(m_att);
         if (exp_m) begin m_found[a] = 1'b1; m_found[b] = 1'b1; end
         if ({ra, rb, pre, mp, mmp} !== {3'b110, exp_m, ~exp_m}) begin
            $display("FAIL rand_turn %0d/%0d: got %b expected %b", a, b, {ra, rb, pre, mp, mmp}, {3'b110, exp_m, ~exp_m}); fails++;
         end
         tests++;
         if (found !== m_found || attempts !== m_att || game_over !== (m_found == ALL)) begin
            $display("FAIL rand_state: got found=%h att=%0d go=%b expected %h %0d %b", found, attempts, game_over, m_found, m_att, m_found == ALL); fails++;
         end
         tests++;
         if (!exp_m) repeat (SC) step();
      end
      if (m_found != ALL) begin
         $display("FAIL rand_play_budget: got %0d turns expected completion", turns); fails++;
      end
      tests++;
      sel_valid = 1'b1; sel_loc = 6'd4;
      step();
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b0 || busy !== 1'b1 || game_over !== 1'b1 || attempts !== m_att) begin
         $display("FAIL done_hold: got rd=%b busy=%b go=%b att=%0d expected 0 1 1 %0d", mem_rd, busy, game_over, attempts, m_att); fails++;
      end
      tests++;
   endtask

   task automatic test_new_game_show();
      logic ra, rb, pre, mp, mmp;
      pulse_new_game();
      play_turn(12, 13, ra, rb, pre, mp, mmp);
      play_turn(14, 17, ra, rb, pre, mp, mmp);
      step();
      new_game = 1'b1; sel_valid = 1'b1; sel_loc = 6'd20;
      step();
      new_game = 1'b0; sel_valid = 1'b0;
      m_found = 36'd0; m_att = 8'd0;
      if (found !== m_found || attempts !== m_att || card1_vis !== 1'b0 || card2_vis !== 1'b0 ||
          busy !== 1'b0 || mem_rd !== 1'b0 || game_over !== 1'b0) begin
         $display("FAIL newgame_in_show: got found=%h att=%0d vis=%b%b busy=%b rd=%b go=%b expected 0 0 00 0 0 0",
                  found, attempts, card1_vis, card2_vis, busy, mem_rd, game_over); fails++;
      end
      tests++;
      sel_valid = 1'b1; sel_loc = 6'd20;
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b1 || mem_addr !== 6'd20) begin
         $display("FAIL pick_after_newgame: got rd=%b addr=%0d expected 1 20", mem_rd, mem_addr); fails++;
      end
      tests++;
   endtask

   task automatic test_reset_read2();
      pulse_new_game();
      sel_valid = 1'b1; sel_loc = 6'd10;
      step();
      sel_valid = 1'b0;
      step();
      sel_valid = 1'b1; sel_loc = 6'd11;
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL read2_entry: got rd=%b busy=%b expected 1 1", mem_rd, busy); fails++;
      end
      tests++;
      #2 reset_n = 1'b0;
      #1;
      if ({mem_rd, mem_addr, card1_loc, card2_loc, card1_vis, card2_vis, match_p, mismatch_p, game_over} !== 21'd0 ||
          found !== 36'd0 || attempts !== 8'd0 || busy !== 1'b1) begin
         $display("FAIL async_reset: got rd=%b addr=%0d locs=%0d,%0d vis=%b%b busy=%b expected all 0 busy 1",
                  mem_rd, mem_addr, card1_loc, card2_loc, card1_vis, card2_vis, busy); fails++;
      end
      tests++;
      @(negedge clock);
      reset_n = 1'b1;
      sel_valid = 1'b1; sel_loc = 6'd0;
      step();
      step();
      sel_valid = 1'b0;
      if (mem_rd !== 1'b0 || busy !== 1'b1 || card1_vis !== 1'b0) begin
         $display("FAIL idle_after_reset: got rd=%b busy=%b vis=%b expected 0 1 0", mem_rd, busy, card1_vis); fails++;
      end
      tests++;
   endtask

   // Main sequence
   initial begin
      for (int k = 0; k < 64; k++) rom[k] = (k < 36) ? 5'(k / 2) : 5'd31;
      test_reset();
      test_first_match();
      test_mismatch();
      test_rejections();
      test_random_play();
      test_new_game_show();
      test_reset_read2();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog against a stalled run
   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
